store_buffer_rv: RTL and testbench

Posted-write buffer between the single-cycle RV32 core's data-memory write port and the shared memory bus. It word-aligns each byte/half/word store, queues it in a small FIFO, and drains entries over a valid/ready bus. The core continues executing while stores are pending. It asserts a stall when the queue is full, or when a load hits a word that still has a queued store.

---
 rtl/store_buffer_rv_pkg.sv | 26 ++
 rtl/store_buffer_rv_if.sv | 11 +
 rtl/store_buffer_rv_sync_fifo.sv | 48 ++++
 rtl/store_buffer_rv.sv | 102 ++++++++++
 tb/tb_store_buffer_rv.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_rv_pkg.sv
// Shared types for the posted-write store buffer: strobe encodings, queued entry record, log2 helper.
package store_buffer_rv_pkg;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } storeEntry_t;

  localparam int ENTRY_W = $bits(storeEntry_t);

  function automatic int log2Ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_rv_if.sv
// Memory-bus write channel: head entry offered with valid, consumed when ready is high.
interface store_buffer_rv_if;
  logic        owBusValid;
  logic [31:0] owBusAddr;
  logic [31:0] owBusData;
  logic [3:0]  owBusWstrb;
  logic        iwBusReady;

  modport master (output owBusValid, owBusAddr, owBusData, owBusWstrb, input iwBusReady);
  modport slave  (input owBusValid, owBusAddr, owBusData, owBusWstrb, output iwBusReady);
endinterface

// File: rtl/store_buffer_rv_sync_fifo.sv
// Storage and pointer FIFO; head is read straight from registered storage (1-cycle write-to-head).
// Push is ignored when full and pop when empty; storage and pointers are exposed for hazard checks.
module store_buffer_rv_sync_fifo
  import store_buffer_rv_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                          iwClk,
  input  logic                          iwRst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              pushData,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [WIDTH-1:0]              headData,
  output logic [DEPTH-1:0][WIDTH-1:0]   entries,
  output logic [log2Ceil(DEPTH):0]      wrPtr,
  output logic [log2Ceil(DEPTH):0]      rdPtr
);
  localparam int AW = log2Ceil(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Extra pointer MSB distinguishes full from empty when the index bits coincide.
  assign full     = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
  assign empty    = (wrPtr == rdPtr);
  assign headData = mem[rdPtr[AW-1:0]];
  assign entries  = mem;

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) begin
        mem[wrPtr[AW-1:0]] <= pushData;
        wrPtr              <= wrPtr + PTR_ONE;
      end
      if (pop && !empty) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/store_buffer_rv.sv
// Posted-write buffer: lane-aligns core stores, queues them, drains one beat per store in order.
// One cycle from accepted store to bus; stalls the core on a full queue or a load hitting a queued word.
module store_buffer_rv
  import store_buffer_rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        iwClk,
  input  logic        iwRst,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  input  logic        iwLoadValid,
  input  logic [31:0] iwLoadAddr,
  output logic        owStall,
  output logic        owMisaligned,
  output logic        owEmpty,
  store_buffer_rv_if.master bus
);
  localparam int AW = log2Ceil(DEPTH);

  logic [1:0]                      off;
  logic [7:0]                      strb8;
  logic [31:0]                     laneData;
  logic                            storeReq;
  logic                            misaligned;
  logic                            full;
  logic                            empty;
  logic                            hit;
  logic                            push;
  logic                            pop;
  storeEntry_t                     pushEntry;
  storeEntry_t                     headEntry;
  logic [ENTRY_W-1:0]              headData;
  logic [DEPTH-1:0][ENTRY_W-1:0]   entries;
  logic [AW:0]                     wrPtr;
  logic [AW:0]                     rdPtr;
  logic [AW:0]                     count;
  logic [DEPTH-1:0]                occupied;
  logic [DEPTH-1:0]                match;
  logic                            unusedLoadLsb;

  assign off        = iwWriteAddr[1:0];
  assign strb8      = {4'b0000, iwWstrb} << off;
  assign laneData   = iwWriteData << {off, 3'b000};
  assign storeReq   = (iwWstrb != STRB_NONE);
  assign misaligned = |strb8[7:4];
  assign pushEntry  = '{addr: iwWriteAddr[31:2], data: laneData, strb: strb8[3:0]};

  // Full comes from registered pointers only, so a same-cycle dequeue does not release the stall.
  assign owStall = (storeReq && full) || hit;
  assign push    = storeReq && !misaligned && !owStall;
  assign pop     = bus.owBusValid && bus.iwBusReady;

  store_buffer_rv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .iwClk    (iwClk),
    .iwRst    (iwRst),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .headData (headData),
    .entries  (entries),
    .wrPtr    (wrPtr),
    .rdPtr    (rdPtr)
  );

  // A slot is live when its distance past the read index is below the occupancy count.
  assign count = wrPtr - rdPtr;

  for (genvar g = 0; g < DEPTH; g++) begin : gHazard
    logic [AW-1:0] rel;
    storeEntry_t   slot;
    assign rel         = AW'(g) - rdPtr[AW-1:0];
    assign slot        = entries[g];
    assign occupied[g] = ({1'b0, rel} < count);
    assign match[g]    = occupied[g] && (slot.addr == iwLoadAddr[31:2]);
  end

  assign hit           = iwLoadValid && (|match);
  assign unusedLoadLsb = ^iwLoadAddr[1:0];

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      owMisaligned <= 1'b0;
    end else begin
      owMisaligned <= storeReq && misaligned;
    end
  end

  assign headEntry      = headData;
  assign owEmpty        = empty;
  assign bus.owBusValid = !empty;
  assign bus.owBusAddr  = {headEntry.addr, 2'b00};
  assign bus.owBusData  = headEntry.data;
  assign bus.owBusWstrb = headEntry.strb;

endmodule

// File: tb/tb_store_buffer_rv.sv
// Bench for store_buffer_rv: queue-level reference model checked every cycle plus directed literal checks.
module tb_store_buffer_rv;
  import store_buffer_rv_pkg::*;

  localparam int DEPTH = 4;

  logic        iwClk = 1'b0;
  logic        iwRst = 1'b1;
  logic [31:0] iwWriteAddr = '0;
  logic [31:0] iwWriteData = '0;
  logic [3:0]  iwWstrb = '0;
  logic        iwLoadValid = 1'b0;
  logic [31:0] iwLoadAddr = '0;
  logic        owStall;
  logic        owMisaligned;
  logic        owEmpty;

  store_buffer_rv_if bus ();

  store_buffer_rv #(.DEPTH(DEPTH)) dut (
    .iwClk        (iwClk),
    .iwRst        (iwRst),
    .iwWriteAddr  (iwWriteAddr),
    .iwWriteData  (iwWriteData),
    .iwWstrb      (iwWstrb),
    .iwLoadValid  (iwLoadValid),
    .iwLoadAddr   (iwLoadAddr),
    .owStall      (owStall),
    .owMisaligned (owMisaligned),
    .owEmpty      (owEmpty),
    .bus          (bus)
  );

  always #5 iwClk = ~iwClk;

  int testsRun = 0;
  int testsFailed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: the pending stores as a queue of bus beats in program order.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t expQ[$];
  logic  expMis = 1'b0;

  function automatic int nBytes(input logic [3:0] s);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) if (s[i]) n++;
    return n;
  endfunction

  function automatic logic modelStall();
    logic h;
    h = 1'b0;
    if (iwLoadValid) begin
      foreach (expQ[k]) if (expQ[k].addr[31:2] == iwLoadAddr[31:2]) h = 1'b1;
    end
    return (nBytes(iwWstrb) != 0 && expQ.size() == DEPTH) || h;
  endfunction

  always @(posedge iwClk or posedge iwRst) begin
    logic  stl;
    logic  mis;
    logic  doPop;
    int    off;
    int    nb;
    beat_t b;
    if (iwRst) begin
      expQ.delete();
      expMis = 1'b0;
    end else begin
      stl   = modelStall();
      off   = int'(iwWriteAddr[1:0]);
      nb    = nBytes(iwWstrb);
      mis   = (nb != 0) && (off + nb > 4);
      doPop = (expQ.size() != 0) && bus.iwBusReady;
      b.addr = {iwWriteAddr[31:2], 2'b00};
      b.data = iwWriteData << (8 * off);
      b.strb = 4'(((1 << nb) - 1) << off);
      if (doPop) void'(expQ.pop_front());
      if (nb != 0 && !mis && !stl) expQ.push_back(b);
      expMis = mis;
    end
  end

  always @(negedge iwClk) begin
    chk("m_valid", {31'b0, bus.owBusValid}, {31'b0, expQ.size() != 0});
    chk("m_empty", {31'b0, owEmpty}, {31'b0, expQ.size() == 0});
    chk("m_stall", {31'b0, owStall}, {31'b0, modelStall()});
    chk("m_misaligned", {31'b0, owMisaligned}, {31'b0, expMis});
    if (expQ.size() != 0) begin
      chk("m_addr", bus.owBusAddr, expQ[0].addr);
      chk("m_data", bus.owBusData, expQ[0].data);
      chk("m_strb", {28'b0, bus.owBusWstrb}, {28'b0, expQ[0].strb});
    end
  end

  task automatic step();
    @(posedge iwClk);
    #2;
  endtask

  initial begin
    bus.iwBusReady = 1'b0;
    #1;
    chk("rst_valid", {31'b0, bus.owBusValid}, 32'd0);
    chk("rst_empty", {31'b0, owEmpty}, 32'd1);
    chk("rst_mis", {31'b0, owMisaligned}, 32'd0);
    chk("rst_stall", {31'b0, owStall}, 32'd0);
    chk("rst_addr", bus.owBusAddr, 32'd0);
    chk("rst_data", bus.owBusData, 32'd0);
    chk("rst_strb", {28'b0, bus.owBusWstrb}, 32'd0);
    repeat (2) step();
    iwRst = 1'b0;
    bus.iwBusReady = 1'b1;

    // Byte store into the top lane of its word.
    iwWriteAddr = 32'h0000_1003; iwWriteData = 32'h0000_00AB; iwWstrb = STRB_BYTE;
    step();
    iwWstrb = STRB_NONE;
    chk("byte_valid", {31'b0, bus.owBusValid}, 32'd1);
    chk("byte_addr", bus.owBusAddr, 32'h0000_1000);
    chk("byte_data", bus.owBusData, 32'hAB00_0000);
    chk("byte_strb", {28'b0, bus.owBusWstrb}, 32'h8);
    step();
    chk("byte_drained", {31'b0, owEmpty}, 32'd1);

    // Aligned half store in the upper half-word.
    iwWriteAddr = 32'h0000_2002; iwWriteData = 32'h0000_1234; iwWstrb = STRB_HALF;
    step();
    iwWstrb = STRB_NONE;
    chk("half_data", bus.owBusData, 32'h1234_0000);
    chk("half_strb", {28'b0, bus.owBusWstrb}, 32'hC);
    step();

    // Half store crossing a word boundary is dropped with a pulse.
    iwWriteAddr = 32'h0000_2003; iwWriteData = 32'h0000_5678; iwWstrb = STRB_HALF;
    #1 chk("mis_nostall", {31'b0, owStall}, 32'd0);
    step();
    iwWstrb = STRB_NONE;
    chk("mis_pulse", {31'b0, owMisaligned}, 32'd1);
    chk("mis_novalid", {31'b0, bus.owBusValid}, 32'd0);
    chk("mis_empty", {31'b0, owEmpty}, 32'd1);
    step();
    chk("mis_pulse_end", {31'b0, owMisaligned}, 32'd0);

    // Fill to DEPTH with the bus stalled; the fifth store must wait.
    bus.iwBusReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iwWriteAddr = 32'h0000_0100 + 32'(4 * i);
      iwWriteData = 32'h1111_0000 + 32'(i);
      iwWstrb     = STRB_WORD;
      #1 chk("fill_stall", {31'b0, owStall}, {31'b0, i == 4});
      if (i < 4) step();
    end
    step();
    bus.iwBusReady = 1'b1;
    #1 chk("full_deq_stall", {31'b0, owStall}, 32'd1);
    step();
    chk("full_head_after_deq", bus.owBusAddr, 32'h0000_0104);
    chk("full_released", {31'b0, owStall}, 32'd0);
    step();
    iwWstrb = STRB_NONE;
    chk("full_head2", bus.owBusAddr, 32'h0000_0108);
    repeat (4) step();
    chk("full_drained", {31'b0, owEmpty}, 32'd1);

    // Load hazard against a queued word.
    bus.iwBusReady = 1'b0;
    iwWriteAddr = 32'h0000_3000; iwWriteData = 32'hDEAD_BEEF; iwWstrb = STRB_WORD;
    step();
    iwWstrb = STRB_NONE;
    iwLoadValid = 1'b1; iwLoadAddr = 32'h0000_3000;
    #1 chk("haz_hit", {31'b0, owStall}, 32'd1);
    step();
    chk("haz_hold", {31'b0, owStall}, 32'd1);
    iwLoadAddr = 32'h0000_3004;
    #1 chk("haz_other_word", {31'b0, owStall}, 32'd0);
    iwLoadAddr = 32'h0000_3000;
    bus.iwBusReady = 1'b1;
    #1 chk("haz_deq_cycle", {31'b0, owStall}, 32'd1);
    step();
    chk("haz_cleared", {31'b0, owStall}, 32'd0);
    iwLoadValid = 1'b0;

    // Reset while entries are pending.
    bus.iwBusReady = 1'b0;
    iwWriteAddr = 32'h0000_0500; iwWriteData = 32'h5555_0000; iwWstrb = STRB_WORD;
    step();
    iwWriteAddr = 32'h0000_0504; iwWriteData = 32'h5555_0004;
    step();
    iwWstrb = STRB_NONE;
    chk("rstmid_pending", {31'b0, bus.owBusValid}, 32'd1);
    #1 iwRst = 1'b1;
    #1;
    chk("rstmid_valid", {31'b0, bus.owBusValid}, 32'd0);
    chk("rstmid_empty", {31'b0, owEmpty}, 32'd1);
    step();
    step();
    iwRst = 1'b0;
    iwWriteAddr = 32'h0000_4000; iwWriteData = 32'hCAFE_F00D; iwWstrb = STRB_WORD;
    step();
    iwWstrb = STRB_NONE;
    chk("post_rst_valid", {31'b0, bus.owBusValid}, 32'd1);
    chk("post_rst_addr", bus.owBusAddr, 32'h0000_4000);
    chk("post_rst_data", bus.owBusData, 32'hCAFE_F00D);
    bus.iwBusReady = 1'b1;
    step();
    chk("post_rst_drained", {31'b0, owEmpty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
